dma_req_splitter: RTL and testbench

//  Drains 84-bit DMA descriptors {addr[63:0], len[19:0]} from the 16x84 register FIFO's read port.

---
 rtl/dma_pkg.sv | 27 ++
 rtl/dma_chunk_calc.sv | 29 ++
 rtl/dma_req_splitter.sv | 95 +++++++++
 tb/tb_dma_req_splitter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request splitter.
// Descriptor layout, FSM states and the payload size clamp.
package dma_pkg;
  localparam int ADDR_W = 64;
  localparam int LEN_W = 20;
  localparam int DESC_W = ADDR_W + LEN_W;
  localparam int MPS_MAX_CODE = 5;
  localparam int BOUNDARY_4K = 4096;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND
  } state_t;

  function automatic logic [2:0] clampMps(
    input logic [2:0] code
  );
    return (code > 3'(MPS_MAX_CODE)) ?
      3'(MPS_MAX_CODE) : code;
  endfunction
endpackage

// File: rtl/dma_chunk_calc.sv
// Chunk size: min(remaining, max payload, bytes to 4 KB).
// Pure combinational; mps must already be clamped to 0..5.
module dma_chunk_calc
  import dma_pkg::*;
#(
  parameter int LEN_W = 20
) (
  input  logic [LEN_W-1:0] remLen,
  input  logic [2:0]       mps,
  input  logic [11:0]      addrLow,
  output logic [12:0]      chunk,
  output logic             last
);
  logic [12:0] mpsBytes;
  logic [12:0] toBoundary;
  logic [12:0] remCap;
  logic [12:0] minA;

  always_comb begin
    mpsBytes = 13'd128 << mps;
    // always 1..4096, never zero
    toBoundary = 13'(BOUNDARY_4K) - {1'b0, addrLow};
    remCap = (remLen > LEN_W'(BOUNDARY_4K)) ?
      13'(BOUNDARY_4K) : remLen[12:0];
    minA = (remCap < mpsBytes) ? remCap : mpsBytes;
    chunk = (minA < toBoundary) ? minA : toBoundary;
    last = (LEN_W'(chunk) == remLen);
  end
endmodule

// File: rtl/dma_req_splitter.sv
// Splits FIFO DMA descriptors into PCIe read requests
// capped by max payload and never crossing 4 KB.
module dma_req_splitter
  import dma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W = 20
) (
  input  logic                    clockCore,
  input  logic                    resetCore,
  input  logic                    fifoEmpty,
  input  logic [ADDR_W+LEN_W-1:0] fifoData,
  output logic                    fifoPop,
  input  logic [2:0]              maxPayload,
  output logic                    reqValid,
  input  logic                    reqReady,
  output logic [ADDR_W-1:0]       reqAddr,
  output logic [12:0]             reqLen,
  output logic                    reqLast,
  output logic                    busy,
  output logic                    zeroLenErr
);
  state_t            state;
  logic [ADDR_W-1:0] curAddr;
  logic [LEN_W-1:0]  remLen;
  logic [2:0]        mps;
  logic [12:0]       chunk;
  logic              last;

  logic [ADDR_W-1:0] headAddr;
  logic [LEN_W-1:0]  headLen;

  assign headAddr = fifoData[LEN_W +: ADDR_W];
  assign headLen = fifoData[LEN_W-1:0];

  // gated by reset so nothing pops while held in reset
  assign fifoPop = resetCore & ~fifoEmpty &
    (state == IDLE);
  assign busy = (state != IDLE);

  dma_chunk_calc #(
    .LEN_W(LEN_W)
  ) uCalc (
    .remLen (remLen),
    .mps    (mps),
    .addrLow(curAddr[11:0]),
    .chunk  (chunk),
    .last   (last)
  );

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state      <= IDLE;
      curAddr    <= '0;
      remLen     <= '0;
      mps        <= '0;
      reqValid   <= 1'b0;
      reqAddr    <= '0;
      reqLen     <= '0;
      reqLast    <= 1'b0;
      zeroLenErr <= 1'b0;
    end else begin
      zeroLenErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            curAddr <= headAddr;
            remLen  <= headLen;
            mps     <= clampMps(maxPayload);
            if (headLen == '0)
              zeroLenErr <= 1'b1;
            else
              state <= CALC;
          end
        end
        CALC: begin
          reqAddr  <= curAddr;
          reqLen   <= chunk;
          reqLast  <= last;
          reqValid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (reqReady) begin
            curAddr  <= curAddr + ADDR_W'(reqLen);
            remLen   <= remLen - LEN_W'(reqLen);
            reqValid <= 1'b0;
            state    <= reqLast ? IDLE : CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_req_splitter.sv
// Scoreboard bench for dma_req_splitter with a
// list-based reference model of descriptor splitting.
module tb_dma_req_splitter;
  import dma_pkg::*;

  logic        clockCore = 1'b0;
  logic        resetCore = 1'b0;
  logic        fifoEmpty = 1'b1;
  logic [83:0] fifoData = '0;
  logic        fifoPop;
  logic [2:0]  maxPayload = 3'd0;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [63:0] reqAddr;
  logic [12:0] reqLen;
  logic        reqLast;
  logic        busy;
  logic        zeroLenErr;

  typedef struct {
    bit          isErr;
    logic [63:0] addr;
    int          len;
    bit          last;
    int          due;
  } exp_t;

  exp_t  expQ[$];
  desc_t fifoQ[$];
  int    descLenQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int popCount = 0;
  int errSeen = 0;
  int readyMode = 0;

  dma_req_splitter dut (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .fifoEmpty (fifoEmpty),
    .fifoData  (fifoData),
    .fifoPop   (fifoPop),
    .maxPayload(maxPayload),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqAddr   (reqAddr),
    .reqLen    (reqLen),
    .reqLast   (reqLast),
    .busy      (busy),
    .zeroLenErr(zeroLenErr)
  );

  always #5 clockCore = ~clockCore;

  initial forever begin
    @(posedge clockCore);
    cyc++;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic refreshFifo();
    fifoEmpty = (fifoQ.size() == 0);
    fifoData = fifoEmpty ? '0 : fifoQ[0];
  endtask

  // Reference: walk the descriptor in byte arithmetic.
  task automatic modelLoad(input desc_t d,
                           input logic [2:0] code,
                           input int popCyc);
    exp_t e;
    int rem;
    int sz;
    int c;
    int toB;
    bit first;
    longint unsigned a;
    rem = int'(d.len);
    a = d.addr;
    sz = 128 << ((code > 3'd5) ? 5 : int'(code));
    first = 1'b1;
    if (rem == 0) begin
      e.isErr = 1'b1;
      e.addr = '0;
      e.len = 0;
      e.last = 1'b0;
      e.due = popCyc + 1;
      expQ.push_back(e);
      return;
    end
    descLenQ.push_back(rem);
    while (rem > 0) begin
      toB = 4096 - int'(a % 64'd4096);
      c = rem;
      if (sz < c) c = sz;
      if (toB < c) c = toB;
      e.isErr = 1'b0;
      e.addr = a;
      e.len = c;
      e.last = (c == rem);
      e.due = first ? popCyc + 2 : -1;
      expQ.push_back(e);
      a += longint'(c);
      rem -= c;
      first = 1'b0;
    end
  endtask

  // FIFO model: pop takes effect at the clock edge.
  initial forever begin
    @(negedge clockCore);
    if (fifoPop) begin
      chk("popWhileEmpty", fifoEmpty, 0);
      if (fifoQ.size() > 0) begin
        modelLoad(fifoQ[0], maxPayload, cyc);
        popCount++;
      end
      @(posedge clockCore);
      #1;
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
      refreshFifo();
    end
  end

  initial forever begin
    @(posedge clockCore);
    #2;
    case (readyMode)
      0: reqReady = ($urandom_range(3) != 0);
      1: reqReady = 1'b0;
      default: reqReady = 1'b1;
    endcase
  end

  // Monitor: compare DUT output against the queue.
  initial begin : monitor
    exp_t e;
    bit stalled;
    int lastHs;
    int sumLen;
    int dueCyc;
    logic [63:0] hAddr;
    logic [12:0] hLen;
    logic hLast;
    stalled = 1'b0;
    lastHs = -100;
    sumLen = 0;
    forever begin
      @(negedge clockCore);
      if (!resetCore) begin
        stalled = 1'b0;
        sumLen = 0;
      end else begin
        if (zeroLenErr) begin
          errSeen++;
          if (expQ.size() == 0 || !expQ[0].isErr)
            fail("unexpectedZeroLenErr");
          else begin
            e = expQ.pop_front();
            chk("zeroLenErrCycle", 64'(cyc), 64'(e.due));
          end
        end
        if (stalled) begin
          chk("validHeld", reqValid, 1);
          if (reqValid) begin
            chk("stableAddr", reqAddr, hAddr);
            chk("stableLen", 64'(reqLen), 64'(hLen));
            chk("stableLast", reqLast, hLast);
          end
        end
        if (reqValid) begin
          if (!stalled) begin
            if (expQ.size() == 0 || expQ[0].isErr)
              fail("unexpectedRequest");
            else begin
              dueCyc = (expQ[0].due >= 0) ?
                expQ[0].due : lastHs + 2;
              chk("validLatency", 64'(cyc), 64'(dueCyc));
            end
          end
          if (reqReady) begin
            if (expQ.size() == 0 || expQ[0].isErr)
              fail("unexpectedHandshake");
            else begin
              e = expQ.pop_front();
              chk("reqAddr", reqAddr, e.addr);
              chk("reqLen", 64'(reqLen), 64'(e.len));
              chk("reqLast", reqLast, e.last);
              chk("no4kCross",
                  (int'(reqAddr[11:0]) + int'(reqLen)) <= 4096,
                  1);
              sumLen += int'(reqLen);
              if (reqLast) begin
                if (descLenQ.size() == 0)
                  fail("descSumNoDesc");
                else
                  chk("descSum", 64'(sumLen),
                      64'(descLenQ.pop_front()));
                sumLen = 0;
              end
            end
            lastHs = cyc;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            hAddr = reqAddr;
            hLen = reqLen;
            hLast = reqLast;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clockCore);
    #2;
  endtask

  task automatic push(input logic [63:0] a, input int l);
    desc_t d;
    d.addr = a;
    d.len = 20'(l);
    fifoQ.push_back(d);
    refreshFifo();
  endtask

  task automatic drain(input string name, input int maxCyc);
    int n;
    n = 0;
    while ((fifoQ.size() != 0 || expQ.size() != 0 || busy)
           && n < maxCyc) begin
      tick();
      n++;
    end
    if (n >= maxCyc) fail(name);
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!reqValid && n < 20) begin
      tick();
      n++;
    end
    chk(name, reqValid, 1);
  endtask

  initial begin : stim
    int pc;
    int ec;
    logic [63:0] a;
    logic [63:0] sA;
    logic [12:0] sL;
    logic sLast;
    int l;
    int r;

    #1;
    chk("rstReqValid", reqValid, 0);
    chk("rstBusy", busy, 0);
    chk("rstZeroLenErr", zeroLenErr, 0);
    chk("rstReqAddr", reqAddr, 0);
    chk("rstReqLen", 64'(reqLen), 0);
    chk("rstReqLast", reqLast, 0);

    // test 1: two 128-byte chunks, one pop
    readyMode = 2;
    maxPayload = 3'd0;
    push(64'h1000, 256);
    #1;
    chk("rstNoPop", fifoPop, 0);
    pc = popCount;
    @(posedge clockCore);
    #3;
    resetCore = 1'b1;
    drain("t1Drain", 100);
    chk("t1Pops", 64'(popCount - pc), 1);
    chk("t1BusyLow", busy, 0);

    // test 2: 4 KB split
    maxPayload = 3'd2;
    push(64'h0FF0, 64);
    drain("t2Drain", 100);

    // test 3: zero length descriptor
    pc = popCount;
    ec = errSeen;
    push(64'h1234, 0);
    drain("t3Drain", 100);
    chk("t3Pops", 64'(popCount - pc), 1);
    chk("t3ErrPulses", 64'(errSeen - ec), 1);
    chk("t3Busy", busy, 0);

    // test 4: mps codes 6/7 clamp to 4096
    maxPayload = 3'd7;
    push(64'h0, 8192);
    drain("t4Drain", 100);

    // test 5: hold ready low 5 cycles
    readyMode = 1;
    maxPayload = 3'd0;
    push(64'h2000, 256);
    push(64'h3000, 128);
    waitValid("t5Valid");
    pc = popCount;
    sA = reqAddr;
    sL = reqLen;
    sLast = reqLast;
    repeat (5) begin
      tick();
      chk("t5Valid", reqValid, 1);
      chk("t5Addr", reqAddr, sA);
      chk("t5Len", 64'(reqLen), 64'(sL));
      chk("t5Last", reqLast, sLast);
    end
    chk("t5NoPop", 64'(popCount), 64'(pc));
    readyMode = 0;
    drain("t5Drain", 400);

    // test 6: async reset mid-SEND of 3-chunk descriptor
    readyMode = 1;
    maxPayload = 3'd0;
    push(64'h5000, 384);
    push(64'h6000, 200);
    waitValid("t6Valid");
    tick();
    #1;
    resetCore = 1'b0;
    #1;
    chk("t6RstValid", reqValid, 0);
    chk("t6RstBusy", busy, 0);
    chk("t6RstPop", fifoPop, 0);
    expQ.delete();
    descLenQ.delete();
    readyMode = 2;
    repeat (2) tick();
    @(posedge clockCore);
    #3;
    resetCore = 1'b1;
    drain("t6Drain", 100);
    chk("t6Consumed", 64'(fifoQ.size()), 0);

    // randomized traffic
    readyMode = 0;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(3));
      a = {$urandom, $urandom};
      if (r == 0)
        a[11:0] = 12'hFFF - 12'($urandom_range(200));
      else if (r == 1)
        a = 64'hFFFF_FFFF_FFFF_F000 |
            64'($urandom_range(4095));
      l = ($urandom_range(9) == 0) ?
        0 : int'($urandom_range(1, 6000));
      push(a, l);
      repeat ($urandom_range(3)) begin
        maxPayload = 3'($urandom_range(7));
        tick();
      end
      while (fifoQ.size() >= 15) tick();
    end
    drain("randDrain", 60000);
    chk("endQueueEmpty", 64'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
